// File: rtl/demux1to2_4b_latch_if.sv
// demux1to2_4b_latch_if
//   Board-side bundle for the registered 1-to-2 demultiplexer.
//   Inputs (raw, asynchronous to clk, active-low buttons):
//     d_n[3:0]  data buttons, pressed = 0
//     s         bank selector switch, 0 = bank A, 1 = bank B
//     load_n    LOAD button, pressed = 0
//   Outputs (registered):
//     a[3:0], b[3:0]  LED banks
//     last_sel        selector used by the most recent write
//     busy            high while a write is in flight or LOAD is still held
//   Modports: master drives the raw inputs (board / testbench),
//             slave is the demultiplexer itself.
`timescale 1ns/1ps
interface demux1to2_4b_latch_if;
  logic [3:0] d_n;
  logic       s;
  logic       load_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       last_sel;
  logic       busy;

  modport master (
    output d_n, s, load_n,
    input  a, b, last_sel, busy
  );

  modport slave (
    input  d_n, s, load_n,
    output a, b, last_sel, busy
  );
endinterface

// File: rtl/demux1to2_4b_latch.sv
// demux1to2_4b_latch
//   Registered 4-bit 1-to-2 demultiplexer. Raw buttons/switch are
//   synchronized and debounced; a debounced LOAD press captures the data
//   (converted to active-high) and the selector, then writes the data into
//   the selected LED bank only. The other bank keeps its value.
//   Ports:
//     clk    system clock (50 MHz)
//     rst_n  asynchronous active-low reset (released synchronously inside)
//     bus    demux1to2_4b_latch_if.slave: d_n, s, load_n in; a, b,
//            last_sel, busy out
//   Parameters:
//     DEBOUNCE_CYCLES  consecutive stable cycles to accept a new level
//     CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
`timescale 1ns/1ps
module demux1to2_4b_latch #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  demux1to2_4b_latch_if.slave      bus
);

  localparam int N_IN = 6;
  // Released level of {load_n, s, d_n[3:0]}: buttons up, selector on bank A.
  localparam logic [N_IN-1:0] REL_LEVEL = 6'b10_1111;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  // Reset: asserts asynchronously, releases two clocks after rst_n rises so
  // every flop leaves reset on the same edge.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  // Two-flop synchronizers followed by per-input debounce.
  logic [N_IN-1:0]  raw;
  logic [N_IN-1:0]  sync1, sync2;
  logic [N_IN-1:0]  deb;
  logic [CNT_W-1:0] cnt [N_IN];

  assign raw = {bus.load_n, bus.s, bus.d_n};

  // NOTE: sequential state is assigned with <= only; mixing in blocking
  // assignments here would make sync2 see this cycle's sync1 and collapse
  // the synchronizer to a single stage.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sync1 <= REL_LEVEL;
      sync2 <= REL_LEVEL;
      deb   <= REL_LEVEL;
      // NOTE: the counter array is small and must start from zero so a
      // stale count cannot shorten the first debounce after reset, so it
      // is reset like ordinary flops rather than left as uninitialized storage.
      for (int i = 0; i < N_IN; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < N_IN; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  logic [3:0] deb_d_n;
  logic       deb_s;
  logic       deb_load_n;
  logic       deb_load_n_q;
  logic       load_fall;

  assign deb_d_n    = deb[3:0];
  assign deb_s      = deb[4];
  assign deb_load_n = deb[5];

  // One-cycle press strobe built from registered levels only.
  assign load_fall = deb_load_n_q & ~deb_load_n;

  state_t     state;
  logic [3:0] data_q;
  logic       sel_q;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      deb_load_n_q <= 1'b1;
      state        <= IDLE;
      data_q       <= '0;
      sel_q        <= 1'b0;
      bus.a        <= '0;
      bus.b        <= '0;
      bus.last_sel <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      deb_load_n_q <= deb_load_n;
      case (state)
        IDLE: begin
          if (load_fall) begin
            data_q   <= ~deb_d_n;
            sel_q    <= deb_s;
            state    <= WRITE;
            bus.busy <= 1'b1;
          end else begin
            bus.busy <= 1'b0;
          end
        end
        WRITE: begin
          if (sel_q) bus.b <= data_q;
          else       bus.a <= data_q;
          bus.last_sel <= sel_q;
          state        <= HOLD;
          bus.busy     <= 1'b1;
        end
        HOLD: begin
          // Wait for a debounced release so one press gives one write.
          if (deb_load_n) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            bus.busy <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux1to2_4b_latch.sv
// tb_demux1to2_4b_latch
//   Directed bench for demux1to2_4b_latch with DEBOUNCE_CYCLES=4, CNT_W=3.
//   Inputs change 1 ns after a rising edge; outputs are sampled at that
//   same point. With that drive point a press reaches the debounced level
//   6 edges later, the FSM enters WRITE on edge 7 and the bank updates on
//   edge 8; a release clears busy on edge 7 after it.
`timescale 1ns/1ps
module tb_demux1to2_4b_latch;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  logic [3:0] exp_a, exp_b;
  logic       exp_sel;

  demux1to2_4b_latch_if bus ();

  demux1to2_4b_latch #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_a"},   8'(bus.a),        8'(exp_a));
    check({tag, "_b"},   8'(bus.b),        8'(exp_b));
    check({tag, "_sel"}, 8'(bus.last_sel), 8'(exp_sel));
  endtask

  // Full press/release cycle with exact latency checks.
  task automatic do_write(input string tag, input logic [3:0] dn, input logic sv);
    logic [3:0] data;
    data = ~dn;
    bus.d_n = dn;
    bus.s   = sv;
    tick(10);
    bus.load_n = 1'b0;
    tick(7);
    check({tag, "_busy_on"}, 8'(bus.busy), 8'd1);
    check_outputs({tag, "_pre"});
    tick(1);
    if (sv) exp_b = data;
    else    exp_a = data;
    exp_sel = sv;
    check_outputs({tag, "_wr"});
    tick(4);
    bus.load_n = 1'b1;
    tick(6);
    check({tag, "_busy_hold"}, 8'(bus.busy), 8'd1);
    tick(1);
    check({tag, "_busy_off"}, 8'(bus.busy), 8'd0);
    tick(3);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_a   = '0;
    exp_b   = '0;
    exp_sel = 1'b0;

    rst_n      = 1'b0;
    bus.d_n    = 4'hF;
    bus.s      = 1'b0;
    bus.load_n = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    check_outputs("reset");
    check("reset_busy", 8'(bus.busy), 8'd0);

    // Data 0101 into bank A, then 1100 into bank B.
    do_write("wrA", 4'b1010, 1'b0);
    do_write("wrB", 4'b0011, 1'b1);

    // Short LOAD glitch with new data/selector: must not write.
    bus.d_n = 4'b0000;
    bus.s   = 1'b0;
    tick(10);
    bus.load_n = 1'b0;
    tick(2);
    bus.load_n = 1'b1;
    tick(5);
    check("glitch_busy_mid", 8'(bus.busy), 8'd0);
    tick(15);
    check_outputs("glitch");
    check("glitch_busy", 8'(bus.busy), 8'd0);

    // Long hold with inputs toggling after capture: exactly one write.
    bus.d_n = 4'b1000;
    bus.s   = 1'b0;
    tick(10);
    bus.load_n = 1'b0;
    tick(8);
    exp_a   = 4'h7;
    exp_sel = 1'b0;
    check_outputs("hold_wr");
    for (int i = 0; i < 92; i++) begin
      bus.s   = ~bus.s;
      bus.d_n = bus.d_n + 4'd3;
      tick(1);
    end
    check_outputs("hold_end");
    check("hold_busy", 8'(bus.busy), 8'd1);
    bus.d_n = 4'b1110;
    bus.s   = 1'b1;
    bus.load_n = 1'b1;
    tick(10);
    check("rel_busy", 8'(bus.busy), 8'd0);
    check_outputs("rel");
    do_write("repress", 4'b1110, 1'b1);

    // Reset asserted while in HOLD: asynchronous clear of everything.
    bus.d_n = 4'b0110;
    bus.s   = 1'b1;
    tick(10);
    bus.load_n = 1'b0;
    tick(9);
    exp_b   = 4'h9;
    exp_sel = 1'b1;
    check_outputs("pre_rst");
    check("pre_rst_busy", 8'(bus.busy), 8'd1);
    #2;
    rst_n      = 1'b0;
    bus.load_n = 1'b1;
    #1;
    exp_a   = '0;
    exp_b   = '0;
    exp_sel = 1'b0;
    check_outputs("async_rst");
    check("async_rst_busy", 8'(bus.busy), 8'd0);
    tick(3);
    rst_n = 1'b1;
    tick(15);
    check_outputs("post_rst");
    check("post_rst_busy", 8'(bus.busy), 8'd0);
    do_write("after_rst", 4'b1001, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux1to2_4b_latch.md
Name: demux1to2_4b_latch

Overview:
- Registered 4-bit 1-to-2 demultiplexer for the Cyclone IV board: one 4-bit button input is routed to one of two 4-bit LED banks, chosen by a DIP-switch selector.
- A debounced LOAD button press captures the data and the selector, then writes the data into the selected bank only. The other bank holds its last value.
- Sits between raw board I/O (buttons, switch) and the LEDs; all inputs are asynchronous to clk.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a new input level (20 ms at 50 MHz).
- CNT_W, 20, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, 50 MHz board oscillator.
- rst_n  input  1  asynchronous active-low reset.
- d_n  input  4  raw data buttons, active-low (pressed = 0).
- s  input  1  raw selector switch: 0 = bank A, 1 = bank B.
- load_n  input  1  raw LOAD button, active-low.
- a  output  4  bank A LEDs, registered.
- b  output  4  bank B LEDs, registered.
- last_sel  output  1  selector used by the most recent write.
- busy  output  1  high in WRITE and HOLD states.

Behaviour:
- Reset (async assert, sync release), all outputs and registers forced:
  - a = 0, b = 0, last_sel = 0, busy = 0, FSM in IDLE.
  - Synchronizers and debounced levels preset to the released level: d_n = 4'hF, load_n = 1, s = 0.
  - All debounce counters = 0.
- Synchronization: each of the 6 raw inputs passes through a 2-flop synchronizer before any other use.
- Debounce, per input:
  - If the synchronized value equals the debounced value, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced value takes the synchronized value and the counter clears.
  - Any bounce back resets the counter, so a glitch shorter than DEBOUNCE_CYCLES never propagates.
- Load edge: load_fall = debounced load_n was 1 last cycle and is 0 now. It is a one-cycle, combinational condition from registered signals.
- FSM states: IDLE, WRITE, HOLD.
  - IDLE:
    - On load_fall, capture data_q = ~deb_d_n (converted to active-high) and sel_q = deb_s, then go to WRITE.
    - Otherwise stay in IDLE.
  - WRITE (exactly 1 cycle):
    - sel_q = 0: a <= data_q. sel_q = 1: b <= data_q.
    - last_sel <= sel_q.
    - Go to HOLD.
  - HOLD:
    - Wait until debounced load_n = 1, then go to IDLE.
    - Data and selector changes are ignored here.
- Latency: bank output changes on the 2nd rising edge after the edge at which debounced load_n falls.
- busy is registered from the next state: it is 1 in the cycle the FSM is in WRITE or HOLD, 0 in IDLE.
- Simultaneous events:
  - Data or selector changes in the same cycle as load_fall: the captured values are the debounced values present at that edge.
  - The selector may change during WRITE/HOLD; this does not alter the write already in flight.
- Holding LOAD down yields exactly one write. A new write requires a release (debounced), then a new press.
- Reset mid-operation (any state) returns to IDLE with both banks cleared; the pending write is lost.
- Non-selected bank is never written. Writing the same value twice is legal and has no side effects.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset then idle 20 cycles -> a=0, b=0, last_sel=0, busy=0.
- d_n=4'b1010 (data 0101), s=0, press load_n for 12 cycles, release -> a=4'h5 exactly 2 edges after debounced load falls; b=0; busy high until load released and debounced.
- Then d_n=4'b0011 (data 1100), s=1, press/release load -> b=4'hC, a stays 4'h5, last_sel=1.
- load_n glitch low for 2 cycles, s=0, new data 4'hF -> no write; a=5, b=C, busy stays 0.
- Hold load_n low 100 cycles while toggling s and d_n after the capture -> exactly one write, using the values at capture; second write only after release and re-press.
- Assert rst_n low during HOLD -> a=0, b=0, busy=0 immediately (asynchronous); after release the FSM is in IDLE and the next press writes normally.
